// File: rtl/lag_pl_output_port.sv
// Output port of a physical-lane router: per-PL credit counters, PL free/busy tracking,
// and a one-cycle registered link stage. Optional feature macro: LAG_RELEASE_ON_EMPTY_EN.
package lag_pl_pkg;

  typedef struct packed {
    logic head;
    logic tail;
  } flit_ctrl_t;

  typedef struct packed {
    flit_ctrl_t  control;
    logic [31:0] data;
  } flit_t;

endpackage

module lag_pl_output_port
  import lag_pl_pkg::*;
#(
  parameter int num_pls       = 4,
  parameter int buffer_length = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  flit_t              flit_in,
  input  logic               flit_valid,
  input  logic [num_pls-1:0] flit_pl,
  input  logic [num_pls-1:0] credit_in,
  input  logic [num_pls-1:0] pl_alloc,
  output flit_t              data_out,
  output logic               valid_out,
  output logic [num_pls-1:0] pl_out,
  output logic [num_pls-1:0] pl_free,
  output logic [num_pls-1:0] can_send,
  output logic               credit_err
);

  localparam int cw = $clog2(buffer_length + 1);
  localparam logic [cw-1:0] cnt_full = cw'(buffer_length);
  localparam logic [cw-1:0] cnt_zero = {cw{1'b0}};
  localparam logic [cw-1:0] cnt_one  = cw'(1);

  typedef enum logic {
    PL_FREE = 1'b0,
    PL_BUSY = 1'b1
  } pl_state_t;

  logic [num_pls-1:0][cw-1:0] cnt;
  logic [num_pls-1:0][cw-1:0] cnt_nxt;
  pl_state_t                  state     [num_pls];
  pl_state_t                  state_nxt [num_pls];
  logic [num_pls-1:0]         send;
  logic [num_pls-1:0]         tail_send;
  logic [num_pls-1:0]         release_lane;
  logic [num_pls-1:0]         cnt_err;
  logic [num_pls-1:0]         alloc_err;
  logic                       pl_onehot;
  logic                       err_nxt;
`ifdef LAG_RELEASE_ON_EMPTY_EN
  logic [num_pls-1:0]         tail_pend;
  logic [num_pls-1:0]         tail_pend_nxt;
`endif

  function automatic logic is_onehot(input logic [num_pls-1:0] v);
    return (v != {num_pls{1'b0}}) && ((v & (v - num_pls'(1))) == {num_pls{1'b0}});
  endfunction

  // Decode the granted flit into per-lane send strobes; malformed PL vectors send nothing
  always_comb begin
    pl_onehot = is_onehot(flit_pl);
    if (flit_valid && pl_onehot) begin
      send = flit_pl;
    end else begin
      send = {num_pls{1'b0}};
    end
    if (flit_in.control.tail) begin
      tail_send = send;
    end else begin
      tail_send = {num_pls{1'b0}};
    end
  end

  // Credit counters: saturate at both ends and flag the over/underflow
  always_comb begin
    for (int i = 0; i < num_pls; i++) begin
      cnt_nxt[i] = cnt[i];
      cnt_err[i] = 1'b0;
      if (send[i] && credit_in[i]) begin
        cnt_nxt[i] = cnt[i];
      end else if (send[i]) begin
        if (cnt[i] == cnt_zero) begin
          cnt_err[i] = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] - cnt_one;
        end
      end else if (credit_in[i]) begin
        if (cnt[i] == cnt_full) begin
          cnt_err[i] = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] + cnt_one;
        end
      end else begin
        cnt_nxt[i] = cnt[i];
      end
    end
  end

  // Per-lane FREE/BUSY next state and release decision
  always_comb begin
    for (int i = 0; i < num_pls; i++) begin
      state_nxt[i] = state[i];
      alloc_err[i] = 1'b0;
`ifdef LAG_RELEASE_ON_EMPTY_EN
      tail_pend_nxt[i] = tail_pend[i];
      release_lane[i]  = (state[i] == PL_BUSY) && tail_pend[i] && (cnt[i] == cnt_full);
`else
      release_lane[i]  = (state[i] == PL_BUSY) && tail_send[i];
`endif
      case (state[i])
        PL_FREE: begin
          if (pl_alloc[i]) begin
`ifdef LAG_RELEASE_ON_EMPTY_EN
            state_nxt[i] = PL_BUSY;
`else
            // a single-flit packet claims and releases the lane in one cycle
            state_nxt[i] = tail_send[i] ? PL_FREE : PL_BUSY;
`endif
          end else begin
            state_nxt[i] = PL_FREE;
          end
        end
        PL_BUSY: begin
          if (pl_alloc[i]) begin
            state_nxt[i] = PL_BUSY;
            alloc_err[i] = ~release_lane[i];
          end else if (release_lane[i]) begin
            state_nxt[i] = PL_FREE;
          end else begin
            state_nxt[i] = PL_BUSY;
          end
        end
        default: begin
          state_nxt[i] = PL_FREE;
        end
      endcase
`ifdef LAG_RELEASE_ON_EMPTY_EN
      if (tail_send[i] && ((state[i] == PL_BUSY) || pl_alloc[i])) begin
        tail_pend_nxt[i] = 1'b1;
      end else if (release_lane[i]) begin
        tail_pend_nxt[i] = 1'b0;
      end else begin
        tail_pend_nxt[i] = tail_pend[i];
      end
`endif
    end
  end

  // Sticky protocol error accumulation
  always_comb begin
    err_nxt = credit_err | (|cnt_err) | (|alloc_err) | (flit_valid & ~pl_onehot);
  end

  // Lane status exports, straight from registered state
  always_comb begin
    for (int i = 0; i < num_pls; i++) begin
      pl_free[i]  = (state[i] == PL_FREE);
      can_send[i] = (cnt[i] != cnt_zero);
    end
  end

  // State registers and one-cycle link stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= {num_pls{cnt_full}};
      data_out   <= '0;
      valid_out  <= 1'b0;
      pl_out     <= {num_pls{1'b0}};
      credit_err <= 1'b0;
      for (int i = 0; i < num_pls; i++) begin
        state[i] <= PL_FREE;
      end
`ifdef LAG_RELEASE_ON_EMPTY_EN
      tail_pend  <= {num_pls{1'b0}};
`endif
    end else begin
      cnt        <= cnt_nxt;
      data_out   <= flit_in;
      valid_out  <= flit_valid;
      pl_out     <= flit_pl;
      credit_err <= err_nxt;
      for (int i = 0; i < num_pls; i++) begin
        state[i] <= state_nxt[i];
      end
`ifdef LAG_RELEASE_ON_EMPTY_EN
      tail_pend  <= tail_pend_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_lag_pl_output_port.sv
// Directed, table-driven bench for lag_pl_output_port (num_pls=4, buffer_length=8),
// with hand sequences for error and reset corner cases.
module tb_lag_pl_output_port;
  import lag_pl_pkg::*;

`ifdef LAG_RELEASE_ON_EMPTY_EN
  localparam bit rel = 1'b1;
`else
  localparam bit rel = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  flit_t      flit_in;
  logic       flit_valid;
  logic [3:0] flit_pl, credit_in, pl_alloc;
  flit_t      data_out;
  logic       valid_out;
  logic [3:0] pl_out, pl_free, can_send;
  logic       credit_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        fv;
    logic [3:0]  fpl;
    logic        head;
    logic        tail;
    logic [31:0] data;
    logic [3:0]  cred;
    logic [3:0]  alloc;
    logic [3:0]  exp_can;
    logic [3:0]  exp_free;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  lag_pl_output_port #(.num_pls(4), .buffer_length(8)) dut (
    .clk(clk), .rst_n(rst_n), .flit_in(flit_in), .flit_valid(flit_valid),
    .flit_pl(flit_pl), .credit_in(credit_in), .pl_alloc(pl_alloc),
    .data_out(data_out), .valid_out(valid_out), .pl_out(pl_out),
    .pl_free(pl_free), .can_send(can_send), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flit_valid = 1'b0;
    flit_pl    = 4'b0000;
    flit_in    = '0;
    credit_in  = 4'b0000;
    pl_alloc   = 4'b0000;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_cnt(input int lane, input int exp);
    check($sformatf("cnt%0d", lane), 64'(dut.cnt[lane]), 64'(exp));
  endtask

  function automatic void add(input logic fv, input logic [3:0] fpl, input logic head,
                              input logic tail, input logic [3:0] cred, input logic [3:0] alloc,
                              input logic [3:0] exp_can, input logic [3:0] exp_free,
                              input logic exp_err);
    vec_t v;
    v.fv = fv; v.fpl = fpl; v.head = head; v.tail = tail;
    v.data = 32'hD000_0000 | 32'(vecs.size());
    v.cred = cred; v.alloc = alloc;
    v.exp_can = exp_can; v.exp_free = exp_free; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  task automatic run_rows(input int lo, input int hi);
    flit_t exp_flit;
    for (int r = lo; r < hi; r++) begin
      flit_valid           = vecs[r].fv;
      flit_pl              = vecs[r].fpl;
      flit_in.control.head = vecs[r].head;
      flit_in.control.tail = vecs[r].tail;
      flit_in.data         = vecs[r].data;
      credit_in            = vecs[r].cred;
      pl_alloc             = vecs[r].alloc;
      tick();
      exp_flit.control.head = vecs[r].head;
      exp_flit.control.tail = vecs[r].tail;
      exp_flit.data         = vecs[r].data;
      check($sformatf("row%0d valid_out", r), 64'(valid_out), 64'(vecs[r].fv));
      check($sformatf("row%0d pl_out", r), 64'(pl_out), 64'(vecs[r].fpl));
      check($sformatf("row%0d data_out", r), 64'(data_out), 64'(exp_flit));
      check($sformatf("row%0d can_send", r), 64'(can_send), 64'(vecs[r].exp_can));
      check($sformatf("row%0d pl_free", r), 64'(pl_free), 64'(vecs[r].exp_free));
      check($sformatf("row%0d credit_err", r), 64'(credit_err), 64'(vecs[r].exp_err));
    end
    idle();
  endtask

  initial begin
    int t3_end, t4_end, sf_end, t2_end;

    // T3: three sends on PL1 (8->5), then send+credit together keeps 5
    for (int k = 0; k < 3; k++) add(1'b1, 4'b0010, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 1'b0);
    add(1'b1, 4'b0010, 1'b0, 1'b0, 4'b0010, 4'b0000, 4'b1111, 4'b1111, 1'b0);
    t3_end = vecs.size();
    // T4/T5: allocate PL2, head/body/tail, three credits back, one idle cycle
    add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0100, 4'b1111, 4'b1011, 1'b0);
    add(1'b1, 4'b0100, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b1011, 1'b0);
    add(1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b1011, 1'b0);
    add(1'b1, 4'b0100, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b1111, rel ? 4'b1011 : 4'b1111, 1'b0);
    for (int k = 0; k < 3; k++) add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0100, 4'b0000, 4'b1111, rel ? 4'b1011 : 4'b1111, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 1'b0);
    t4_end = vecs.size();
    // Single-flit packet on PL1 (cnt 5->4), four credits restore 8
    add(1'b1, 4'b0010, 1'b1, 1'b1, 4'b0000, 4'b0010, 4'b1111, rel ? 4'b1101 : 4'b1111, 1'b0);
    for (int k = 0; k < 4; k++) add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0010, 4'b0000, 4'b1111, rel ? 4'b1101 : 4'b1111, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 1'b0);
    sf_end = vecs.size();
    // T2: eight sends drain PL0, the ninth underflows
    for (int k = 1; k <= 8; k++) add(1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0000, (k == 8) ? 4'b1110 : 4'b1111, 4'b1111, 1'b0);
    add(1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1110, 4'b1111, 1'b1);
    t2_end = vecs.size();

    // T1: reset state
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst can_send", 64'(can_send), 64'h0F);
    check("rst pl_free", 64'(pl_free), 64'h0F);
    check("rst valid_out", 64'(valid_out), 64'h0);
    check("rst pl_out", 64'(pl_out), 64'h0);
    check("rst data_out", 64'(data_out), 64'h0);
    check("rst credit_err", 64'(credit_err), 64'h0);
    for (int i = 0; i < 4; i++) check_cnt(i, 8);

    run_rows(0, t3_end);
    check_cnt(1, 5);
    run_rows(t3_end, t4_end);
    check_cnt(2, 8);
    run_rows(t4_end, sf_end);
    check_cnt(1, 8);
    run_rows(sf_end, t2_end);
    check_cnt(0, 0);

    // T6a: credit overflow on a full lane
    do_reset();
    check("t6 rst credit_err", 64'(credit_err), 64'h0);
    credit_in = 4'b1000;
    tick();
    idle();
    check("t6 overflow err", 64'(credit_err), 64'h1);
    check_cnt(3, 8);

    // T6b: allocation of a busy lane
    do_reset();
    pl_alloc = 4'b0001;
    tick();
    check("t6 alloc1 free", 64'(pl_free), 64'h0E);
    check("t6 alloc1 err", 64'(credit_err), 64'h0);
    tick();
    idle();
    check("t6 alloc2 err", 64'(credit_err), 64'h1);
    check("t6 alloc2 free", 64'(pl_free), 64'h0E);

    // T6c: PL vector that is not one-hot
    do_reset();
    flit_valid = 1'b1;
    flit_pl    = 4'b0011;
    tick();
    idle();
    check("t6 mh err", 64'(credit_err), 64'h1);
    check("t6 mh valid_out", 64'(valid_out), 64'h1);
    check_cnt(0, 8);
    check_cnt(1, 8);

    // T6d: reset asserted mid-packet
    do_reset();
    pl_alloc             = 4'b0100;
    flit_valid           = 1'b1;
    flit_pl              = 4'b0100;
    flit_in.control.head = 1'b1;
    tick();
    check("t6 mid free", 64'(pl_free), 64'h0B);
    check_cnt(2, 7);
    pl_alloc             = 4'b0000;
    flit_in.control.head = 1'b0;
    rst_n                = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    check("t6 mid rst free", 64'(pl_free), 64'h0F);
    check("t6 mid rst can", 64'(can_send), 64'h0F);
    check("t6 mid rst valid", 64'(valid_out), 64'h0);
    check("t6 mid rst err", 64'(credit_err), 64'h0);
    for (int i = 0; i < 4; i++) check_cnt(i, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
